episode_sched: RTL and testbench

EPISODE_SCHED -- requirements
Module: episode_sched

---
 rtl/episode_sched.sv | 117 +++++++++++
 tb/tb_episode_sched.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/episode_sched.sv
// Episode sequencer: broadcasts each reward to all agents, collects their done
// edges (or times out), emits the action vector, and counts rounds per episode.
module episode_sched #(
   parameter int N_AG     = 2,
   parameter int RW       = 16,
   parameter int AW       = 9,
   parameter int N_ROUNDS = 250,
   parameter int TMO      = 1023
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic [RW-1:0]        r_in,
   input  logic                 r_valid,
   output logic                 r_ready,
   output logic [N_AG-1:0]      ag_v,
   output logic [RW-1:0]        ag_r,
   input  logic [N_AG*AW-1:0]   ag_a,
   input  logic [N_AG-1:0]      ag_d,
   output logic [N_AG*AW-1:0]   act_out,
   output logic                 act_valid,
   input  logic                 act_ready,
   output logic [N_AG-1:0]      tmo_mask,
   output logic [15:0]          round_cnt,
   output logic                 busy,
   output logic                 ep_done
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_WAIT_R = 3'd1;
   localparam logic [2:0] S_ISSUE  = 3'd2;
   localparam logic [2:0] S_WAIT_D = 3'd3;
   localparam logic [2:0] S_EMIT   = 3'd4;
   localparam logic [2:0] S_FINISH = 3'd5;

   logic [2:0]      state;
   logic [N_AG-1:0] d_prev;
   logic [N_AG-1:0] flags;
   logic [N_AG-1:0] d_edge;
   logic [N_AG-1:0] flags_nxt;
   logic [15:0]     timer;
   logic [15:0]     round_inc;

   // d_prev tracks ag_d in every state, so a level left high from an earlier
   // round never looks like a fresh edge.
   assign d_edge    = ag_d & ~d_prev;
   assign flags_nxt = flags | d_edge;
   assign round_inc = round_cnt + 16'd1;

   assign r_ready   = (state == S_WAIT_R);
   assign ag_v      = {N_AG{state == S_ISSUE}};
   assign act_valid = (state == S_EMIT);
   assign busy      = (state != S_IDLE);
   assign ep_done   = (state == S_FINISH);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         d_prev    <= '0;
         flags     <= '0;
         timer     <= '0;
         round_cnt <= '0;
         ag_r      <= '0;
         act_out   <= '0;
         tmo_mask  <= '0;
      end else begin
         d_prev <= ag_d;
         if (abort) begin
            state <= S_IDLE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     round_cnt <= '0;
                     state     <= S_WAIT_R;
                  end
               end
               S_WAIT_R: begin
                  if (r_valid) begin
                     ag_r  <= r_in;
                     state <= S_ISSUE;
                  end
               end
               S_ISSUE: begin
                  flags    <= '0;
                  tmo_mask <= '0;
                  timer    <= '0;
                  state    <= S_WAIT_D;
               end
               S_WAIT_D: begin
                  timer <= timer + 16'd1;
                  flags <= flags_nxt;
                  if (&flags) begin
                     act_out <= ag_a;
                     state   <= S_EMIT;
                  end else if (timer == 16'(TMO)) begin
                     // an edge landing on the deadline cycle still counts as done
                     act_out  <= ag_a;
                     tmo_mask <= ~flags_nxt;
                     state    <= S_EMIT;
                  end
               end
               S_EMIT: begin
                  if (act_ready) begin
                     round_cnt <= round_inc;
                     state     <= (round_inc == 16'(N_ROUNDS)) ? S_FINISH : S_WAIT_R;
                  end
               end
               S_FINISH: state <= S_IDLE;
               default:  state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_episode_sched.sv
// Randomized bench for episode_sched: a per-round model predicts emit cycle,
// action vector and timeout mask from agent done offsets; a monitor scores them.
module tb_episode_sched;
   localparam int NA = 2, RW = 16, AW = 9, NR = 3, TM = 20;

   logic               clk = 1'b0;
   logic               rst, start, abort, r_valid, r_ready;
   logic [RW-1:0]      r_in, ag_r;
   logic [NA-1:0]      ag_v, ag_d, tmo_mask;
   logic [NA*AW-1:0]   ag_a, act_out;
   logic               act_valid, act_ready, busy, ep_done;
   logic [15:0]        round_cnt;

   episode_sched #(.N_AG(NA), .RW(RW), .AW(AW), .N_ROUNDS(NR), .TMO(TM)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .r_in(r_in),
      .r_valid(r_valid), .r_ready(r_ready), .ag_v(ag_v), .ag_r(ag_r),
      .ag_a(ag_a), .ag_d(ag_d), .act_out(act_out), .act_valid(act_valid),
      .act_ready(act_ready), .tmo_mask(tmo_mask), .round_cnt(round_cnt),
      .busy(busy), .ep_done(ep_done));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [NA*AW-1:0] act;
      logic [NA-1:0]    mask;
      int               cyc;
   } exp_t;
   exp_t exp_q[$];

   int checks = 0, failures = 0;
   int rc_exp = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // Monitor: scores each new EMIT against the queue and checks it stays stable.
   logic             prev_av, prev_agv;
   logic [NA*AW-1:0] held_act;
   logic [NA-1:0]    held_mask;
   initial begin
      exp_t e;
      prev_av = 1'b0; prev_agv = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_av = 1'b0; prev_agv = 1'b0;
         end else begin
            if (|ag_v) begin
               chk("ag_v_all_ones", 64'(ag_v), 64'({NA{1'b1}}));
               chk("ag_v_one_cycle", 64'(prev_agv), 64'd0);
            end
            if (act_valid && !prev_av) begin
               if (exp_q.size() == 0) chk("unexpected_act_valid", 64'(act_valid), 64'd0);
               else begin
                  e = exp_q.pop_front();
                  chk("act_out", 64'(act_out), 64'(e.act));
                  chk("tmo_mask", 64'(tmo_mask), 64'(e.mask));
                  chk("emit_cycle", 64'(cyc), 64'(e.cyc));
               end
               held_act = act_out; held_mask = tmo_mask;
            end else if (act_valid) begin
               chk("act_out_stable", 64'(act_out), 64'(held_act));
               chk("tmo_mask_stable", 64'(tmo_mask), 64'(held_mask));
            end
            if (act_valid) chk("no_r_ready_in_emit", 64'(r_ready), 64'd0);
            prev_av = act_valid; prev_agv = |ag_v;
         end
      end
   end

   task automatic start_ep();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      chk("busy_after_start", 64'(busy), 64'd1);
      chk("round_cnt_cleared", 64'(round_cnt), 64'd0);
      rc_exp = 0;
   endtask

   // Offers a reward; returns the cycle in which ag_v should be pulsing.
   task automatic give_reward(input logic [RW-1:0] rw, input int rdly, output int c, output bit ok);
      int n;
      repeat (rdly) @(posedge clk);
      @(posedge clk); #1 r_in = rw; r_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!r_ready && n < 50) begin @(negedge clk); n++; end
      c = cyc;
      if (!r_ready) begin
         chk("r_ready_timeout", 64'(r_ready), 64'd1);
         r_valid = 1'b0; ok = 1'b0;
         return;
      end
      @(posedge clk); #1 r_valid = 1'b0; r_in = RW'($urandom);
      @(negedge clk);
      chk("ag_v_latency", 64'(|ag_v), 64'd1);
      chk("ag_r", 64'(ag_r), 64'(rw));
      c = cyc; ok = 1'b1;
   endtask

   // j0/j1: cycle offset after the ag_v cycle at which each agent's done rises
   // (-1 = never). An agent already high is dropped one cycle before its rise.
   task automatic run_round(input logic [RW-1:0] rw, input int j0, input int j1,
                            input int hold, input int rdly);
      int jv[NA];
      int c, d, jmax, n;
      bit all, ok;
      logic [NA-1:0] m;
      exp_t e;
      jv[0] = j0; jv[1] = j1;
      give_reward(rw, rdly, c, ok);
      if (!ok) return;
      e.act = (NA*AW)'({$urandom, $urandom});
      ag_a = e.act;
      all = 1'b1; jmax = 0;
      for (int k = 0; k < NA; k++) begin
         if (ag_d[k] && jv[k] == 1) jv[k] = 2;
         if (jv[k] < 1) all = 1'b0;
         else if (jv[k] > jmax) jmax = jv[k];
      end
      d = (all && jmax + 1 < TM + 1) ? jmax + 1 : TM + 1;
      for (int k = 0; k < NA; k++) m[k] = !(jv[k] >= 1 && jv[k] <= d);
      e.mask = m; e.cyc = c + d + 1;
      exp_q.push_back(e);
      n = 0;
      forever begin
         @(posedge clk); #1 n++;
         for (int k = 0; k < NA; k++) begin
            if (jv[k] >= 1 && n == jv[k] - 1) ag_d[k] = 1'b0;
            if (n == jv[k]) ag_d[k] = 1'b1;
         end
         act_ready = (cyc < e.cyc) ? 1'($urandom_range(0, 1)) : 1'b0;
         @(negedge clk);
         if (act_valid) break;
         if (n > 60) begin
            chk("act_valid_timeout", 64'(act_valid), 64'd1);
            act_ready = 1'b0;
            return;
         end
      end
      ag_a = (NA*AW)'($urandom);
      repeat (hold) begin
         @(posedge clk); #1 ag_d = NA'($urandom);
         @(negedge clk);
         chk("round_cnt_held", 64'(round_cnt), 64'(rc_exp));
         chk("act_valid_held", 64'(act_valid), 64'd1);
      end
      @(posedge clk); #1 act_ready = 1'b1;
      @(posedge clk); #1 act_ready = 1'b0;
      rc_exp++;
      @(negedge clk);
      chk("round_cnt_inc", 64'(round_cnt), 64'(rc_exp));
      chk("act_valid_dropped", 64'(act_valid), 64'd0);
      if (rc_exp == NR) begin
         chk("ep_done_pulse", 64'(ep_done), 64'd1);
         @(negedge clk);
         chk("ep_done_one_cycle", 64'(ep_done), 64'd0);
         chk("idle_after_finish", 64'(busy), 64'd0);
         chk("round_cnt_final", 64'(round_cnt), 64'(NR));
      end else begin
         chk("r_ready_next_round", 64'(r_ready), 64'd1);
      end
   endtask

   function automatic int rj();
      return ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(1, 24));
   endfunction

   initial begin
      int c;
      bit ok;
      logic [RW-1:0] saved_r;
      rst = 1'b1; start = 1'b1; abort = 1'b0; r_in = '0; r_valid = 1'b0;
      ag_a = '0; ag_d = '0; act_ready = 1'b0;
      #3;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_outputs", 64'({r_ready, ag_v, act_valid, ep_done, tmo_mask}), 64'd0);
      chk("rst_round_cnt", 64'(round_cnt), 64'd0);
      chk("rst_data", 64'({ag_r, act_out}), 64'd0);
      repeat (3) @(negedge clk);
      chk("start_ignored_in_rst", 64'(busy), 64'd0);
      rst = 1'b0; start = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("idle_no_ag_v", 64'({busy, ag_v}), 64'd0);
      end

      // nominal episode
      start_ep();
      run_round(16'h1234, 5, 5, 0, 0);
      run_round(16'h0042, 5, 5, 1, 2);
      run_round(16'h7FFF, 5, 5, 0, 0);

      // timeout with long backpressure, stale levels, deadline-edge cases
      start_ep();
      run_round(16'hA5A5, 5, -1, 10, 0);
      run_round(16'h0F0F, 3, 8, 0, 0);
      run_round(16'h5A5A, 4, -1, 0, 0);
      ag_d = '0;
      start_ep();
      run_round(16'h0101, 21, 3, 0, 0);
      run_round(16'h0202, 22, 3, 0, 0);
      run_round(16'h0303, 1, 20, 0, 1);

      // abort in WAIT_D of round 2
      ag_d = '0;
      start_ep();
      run_round(16'h1111, 2, 3, 0, 0);
      give_reward(16'h2222, 0, c, ok);
      repeat (3) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0; ag_d = '1;
      @(negedge clk);
      chk("abort_idle", 64'({busy, act_valid, r_ready, ag_v}), 64'd0);
      repeat (8) @(negedge clk);
      chk("abort_no_emit", 64'({busy, act_valid}), 64'd0);
      ag_d = '0;
      start_ep();

      // abort on the same cycle as the reward handshake
      saved_r = ag_r;
      @(posedge clk); #1 r_in = 16'hDEAD; r_valid = 1'b1; abort = 1'b1;
      @(posedge clk); #1 r_valid = 1'b0; abort = 1'b0;
      @(negedge clk);
      chk("abort_reward_idle", 64'(busy), 64'd0);
      chk("abort_reward_discard", 64'(ag_r), 64'(saved_r));
      @(negedge clk);
      chk("abort_reward_no_ag_v", 64'(ag_v), 64'd0);

      // async reset between edges during WAIT_D of round 2
      start_ep();
      run_round(16'h3333, 2, 2, 0, 0);
      give_reward(16'h4444, 0, c, ok);
      @(negedge clk); #2 rst = 1'b1;
      #1;
      chk("async_rst_busy", 64'(busy), 64'd0);
      chk("async_rst_round_cnt", 64'(round_cnt), 64'd0);
      chk("async_rst_ag_r", 64'(ag_r), 64'd0);
      start = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      chk("post_rst_idle", 64'({busy, ag_v}), 64'd0);

      // random episodes
      repeat (4) begin
         start_ep();
         repeat (NR) run_round(RW'($urandom), rj(), rj(),
                               int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
